fetch_seq_ctrl: RTL and testbench
=================================

// Module: fetch_seq_ctrl
// PURPOSE
//  Sequencer for the L1 instruction-fetch path. Owns the fetch PC and drives icache lookups.
//  Pushes hit lines into the instruction queue, runs the line refill from memory on a miss,
//  and applies branch/exception redirects.
//  Sits between the backend (redirect source), the icache, the instruction queue and the memory port.
// PARAMETERS
//  ADDR_SIZE        64                  fetch address width (from lagarto0_pkg)
//  ICACHE_LINE_SIZE 128                 line width in bits; one line per iqueue write
//  LINE_BYTES       ICACHE_LINE_SIZE/8  line size in bytes, power of two (16 by default)
//  RESET_ADDRESS    64'h0               PC value after reset
// PORTS
//  clk_i            in   1                 clock, rising edge
//  rst_i            in   1                 synchronous reset, active-high
//  redirect_i       in   1                 backend redirect strobe (branch/flush)
//  redirect_pc_i    in   ADDR_SIZE         redirect target; bits [1:0] ignored (forced 0)
//  iq_full_i        in   1                 instruction queue full
//  iq_wr_o          out  1                 push current icache line into iqueue
//  iq_flush_o       out  1                 one-cycle pulse: discard iqueue contents
//  ic_req_o         out  1                 icache lookup valid
//  ic_pc_o          out  ADDR_SIZE         lookup address (= fetch PC)
//  ic_hit_i         in   1                 same-cycle hit for ic_pc_o
//  ic_refill_we_o   out  1                 write refill line into icache
//  ic_refill_addr_o out  ADDR_SIZE         line-aligned refill address
//  ic_refill_line_o out  ICACHE_LINE_SIZE  refill data
//  mem_req_o        out  1                 line read request; held until mem_ack_i
//  mem_addr_o       out  ADDR_SIZE         line-aligned request address; stable while mem_req_o=1
//  mem_ack_i        in   1                 one-cycle response strobe with data
//  mem_line_i       in   ICACHE_LINE_SIZE  response data, valid with mem_ack_i
//  busy_o           out  1                 state != LOOKUP
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): state=LOOKUP, pc_q=RESET_ADDRESS.
//    All strobes (iq_wr_o, iq_flush_o, mem_req_o, ic_refill_we_o) are 0. Refill buffer is cleared.
//    An in-flight memory request is abandoned; memory shares rst_i.
//  - Line alignment: line_pc = pc_q & ~(LINE_BYTES-1). Next PC = line_pc + LINE_BYTES,
//    computed modulo 2^ADDR_SIZE (wraps to 0 at the top).
//  - LOOKUP: ic_req_o=1, ic_pc_o=pc_q.
//      hit & !iq_full_i   -> iq_wr_o=1 (combinational), pc_q <= next PC. Throughput is 1 line/cycle.
//      hit & iq_full_i    -> hold pc_q, iq_wr_o=0.
//      miss               -> MISS; mem_addr_o latched to line_pc.
//  - MISS: mem_req_o=1.
//      On mem_ack_i: buf <= mem_line_i, then -> REFILL.
//  - REFILL (exactly 1 cycle): ic_refill_we_o=1, ic_refill_addr_o=line_pc,
//    ic_refill_line_o=buf, -> LOOKUP. The lookup replays at the same pc_q.
//    Miss-to-first-write latency = ack cycle + 2.
//  - DRAIN: mem_req_o=1 (same address). On mem_ack_i, data is discarded, -> LOOKUP.
//  - Redirect has the highest priority, in every state:
//    pc_q <= {redirect_pc_i[ADDR_SIZE-1:2],2'b00}; iq_flush_o=1 in the same cycle.
//      LOOKUP        : iq_wr_o is forced to 0 this cycle; stay LOOKUP.
//      MISS, no ack  : -> DRAIN.
//      MISS with ack : data dropped, -> LOOKUP.
//      REFILL        : the refill write still completes; -> LOOKUP at the new PC.
//      DRAIN         : PC updated again; remain DRAIN.
//  - rst_i wins over redirect_i.
//  - Only one memory request is ever outstanding. mem_req_o deasserts the cycle after mem_ack_i.
//  - ic_req_o=0 outside LOOKUP. ic_hit_i is ignored when ic_req_o=0.
// STRUCTURE
//  - Add to lagarto0_pkg:
//      typedef enum logic [1:0] {FS_LOOKUP, FS_MISS, FS_REFILL, FS_DRAIN} fetch_state_t;
//      localparam LINE_BYTES. RESET_ADDRESS already lives there.
//  - Sub-module fetch_pc_gen: pc_q register with priority reset > redirect > advance > hold.
//    Provides the line_pc and next-PC outputs.
//  - The FSM and refill buffer stay in fetch_seq_ctrl. No other sub-modules.
// TESTING
//  1 Reset: rst_i=1 for 2 cycles
//      -> pc=0, state LOOKUP, all strobes 0. First lookup at 0x0.
//  2 Streaming hits: ic_hit_i=1, iq_full_i=0 for 4 cycles
//      -> iq_wr_o=1 every cycle; ic_pc_o = 0x0,0x10,0x20,0x30.
//  3 Back-pressure: hit with iq_full_i=1 for 3 cycles at pc 0x20
//      -> iq_wr_o=0, pc stays 0x20. Resumes on the cycle full drops.
//  4 Miss/refill: miss at 0x44, mem_ack_i 5 cycles later with line 0xA5..
//      -> mem_addr_o=0x40; ic_refill_we_o 1 cycle after ack at 0x40;
//         the replayed lookup at 0x44 hits and writes.
//  5 Redirect during MISS: redirect to 0x1002 before ack
//      -> iq_flush_o pulse, DRAIN. The ack is consumed without a refill write;
//         next lookup at 0x1000.
//  6 Wrap and simultaneous events:
//      pc=0xFFFF_FFFF_FFFF_FFF0 hit -> next pc 0x0.
//      redirect with rst_i=1 -> reset value.
//      redirect with ack in MISS -> no refill, LOOKUP at target.

Source files
------------

// File: rtl/lagarto0_pkg.sv
// Shared fetch-path types and constants for the lagarto0 core.
package lagarto0_pkg;

    localparam int ADDR_SIZE        = 64;
    localparam int ICACHE_LINE_SIZE = 128;
    localparam int LINE_BYTES       = ICACHE_LINE_SIZE / 8;

    localparam logic [ADDR_SIZE-1:0] RESET_ADDRESS = '0;

    typedef enum logic [1:0] {
        FS_LOOKUP,
        FS_MISS,
        FS_REFILL,
        FS_DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch PC register: reset > redirect > advance > hold, plus line-aligned and next-line PCs.
module fetch_pc_gen
    import lagarto0_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 redirect_i,
    input  logic [ADDR_SIZE-1:0] redirect_pc_i,
    input  logic                 advance_i,
    output logic [ADDR_SIZE-1:0] pc_o,
    output logic [ADDR_SIZE-1:0] line_pc_o,
    output logic [ADDR_SIZE-1:0] next_pc_o
);

    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~(ADDR_SIZE'(LINE_BYTES) - ADDR_SIZE'(1));
    localparam logic [ADDR_SIZE-1:0] WORD_MASK = ~ADDR_SIZE'(3);

    logic [ADDR_SIZE-1:0] pc_q;

    assign pc_o      = pc_q;
    assign line_pc_o = pc_q & LINE_MASK;
    // Sequential fetch always moves to the start of the following line; wraps at the top.
    assign next_pc_o = line_pc_o + ADDR_SIZE'(LINE_BYTES);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_ADDRESS;
        end else if (redirect_i) begin
            pc_q <= redirect_pc_i & WORD_MASK;
        end else if (advance_i) begin
            pc_q <= next_pc_o;
        end
    end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// L1 instruction-fetch sequencer: icache lookup, iqueue push, line refill and redirect handling.
module fetch_seq_ctrl
    import lagarto0_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        redirect_i,
    input  logic [ADDR_SIZE-1:0]        redirect_pc_i,
    input  logic                        iq_full_i,
    output logic                        iq_wr_o,
    output logic                        iq_flush_o,
    output logic                        ic_req_o,
    output logic [ADDR_SIZE-1:0]        ic_pc_o,
    input  logic                        ic_hit_i,
    output logic                        ic_refill_we_o,
    output logic [ADDR_SIZE-1:0]        ic_refill_addr_o,
    output logic [ICACHE_LINE_SIZE-1:0] ic_refill_line_o,
    output logic                        mem_req_o,
    output logic [ADDR_SIZE-1:0]        mem_addr_o,
    input  logic                        mem_ack_i,
    input  logic [ICACHE_LINE_SIZE-1:0] mem_line_i,
    output logic                        busy_o
);

    fetch_state_t state_q, state_d;

    logic [ADDR_SIZE-1:0]        pc, line_pc, next_pc;
    logic                        advance;
    logic                        addr_load, buf_load;
    logic [ADDR_SIZE-1:0]        mem_addr_q;
    logic [ICACHE_LINE_SIZE-1:0] buf_q;

    fetch_pc_gen u_pc_gen (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .advance_i     (advance),
        .pc_o          (pc),
        .line_pc_o     (line_pc),
        .next_pc_o     (next_pc)
    );

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        iq_wr_o        = 1'b0;
        iq_flush_o     = redirect_i;
        ic_req_o       = 1'b0;
        mem_req_o      = 1'b0;
        ic_refill_we_o = 1'b0;
        advance        = 1'b0;
        addr_load      = 1'b0;
        buf_load       = 1'b0;

        unique case (state_q)
            FS_LOOKUP: begin
                ic_req_o = 1'b1;
                if (!redirect_i) begin
                    if (ic_hit_i) begin
                        iq_wr_o = !iq_full_i;
                        advance = !iq_full_i;
                    end else begin
                        addr_load = 1'b1;
                        state_d   = FS_MISS;
                    end
                end
            end
            FS_MISS: begin
                mem_req_o = 1'b1;
                // A redirect makes the outstanding line useless; drain it instead of refilling.
                if (mem_ack_i) begin
                    buf_load = !redirect_i;
                    state_d  = redirect_i ? FS_LOOKUP : FS_REFILL;
                end else if (redirect_i) begin
                    state_d = FS_DRAIN;
                end
            end
            FS_REFILL: begin
                ic_refill_we_o = 1'b1;
                state_d        = FS_LOOKUP;
            end
            FS_DRAIN: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    state_d = FS_LOOKUP;
                end
            end
            default: state_d = FS_LOOKUP;
        endcase
    end

    // NOTE: the refill buffer is a plain register, so it is cleared on reset like any other flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= FS_LOOKUP;
            mem_addr_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q <= state_d;
            if (addr_load) begin
                mem_addr_q <= line_pc;
            end
            if (buf_load) begin
                buf_q <= mem_line_i;
            end
        end
    end

    // pc is frozen from miss to refill, so line_pc still names the missing line here.
    assign ic_pc_o          = pc;
    assign ic_refill_addr_o = line_pc;
    assign ic_refill_line_o = buf_q;
    assign mem_addr_o       = mem_addr_q;
    assign busy_o           = (state_q != FS_LOOKUP);

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed vector table, corner sequences, random vs model.
module tb_fetch_seq_ctrl;

    typedef struct {
        logic         rst;
        logic         redir;
        logic [63:0]  rpc;
        logic         full;
        logic         hit;
        logic         ack;
        logic [127:0] line;
    } in_t;

    typedef struct {
        logic         wr;
        logic         flush;
        logic         icreq;
        logic [63:0]  pc;
        logic         mreq;
        logic [63:0]  maddr;
        logic         rwe;
        logic [63:0]  raddr;
        logic [127:0] rline;
        logic         busy;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] JUNK    = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    localparam logic [127:0] LINE_2  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

    logic         clk_i = 1'b0;
    logic         rst_i, redirect_i, iq_full_i, ic_hit_i, mem_ack_i;
    logic [63:0]  redirect_pc_i;
    logic [127:0] mem_line_i;
    logic         iq_wr_o, iq_flush_o, ic_req_o, ic_refill_we_o, mem_req_o, busy_o;
    logic [63:0]  ic_pc_o, ic_refill_addr_o, mem_addr_o;
    logic [127:0] ic_refill_line_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_i = ~clk_i;

    fetch_seq_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .iq_full_i        (iq_full_i),
        .iq_wr_o          (iq_wr_o),
        .iq_flush_o       (iq_flush_o),
        .ic_req_o         (ic_req_o),
        .ic_pc_o          (ic_pc_o),
        .ic_hit_i         (ic_hit_i),
        .ic_refill_we_o   (ic_refill_we_o),
        .ic_refill_addr_o (ic_refill_addr_o),
        .ic_refill_line_o (ic_refill_line_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack_i),
        .mem_line_i       (mem_line_i),
        .busy_o           (busy_o)
    );

    function automatic in_t mi(logic redir, logic [63:0] rpc, logic full, logic hit,
                               logic ack, logic [127:0] line);
        in_t r;
        r.rst = 1'b0; r.redir = redir; r.rpc = rpc;
        r.full = full; r.hit = hit; r.ack = ack; r.line = line;
        return r;
    endfunction

    function automatic exp_t base_exp(logic flush);
        exp_t e;
        e.wr = 1'b0; e.flush = flush; e.icreq = 1'b0; e.pc = '0; e.mreq = 1'b0;
        e.maddr = '0; e.rwe = 1'b0; e.raddr = '0; e.rline = '0; e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t me_lk(logic [63:0] pc, logic wr, logic flush);
        exp_t e = base_exp(flush);
        e.icreq = 1'b1; e.pc = pc; e.wr = wr; e.busy = 1'b0;
        return e;
    endfunction

    function automatic exp_t me_miss(logic [63:0] maddr, logic flush);
        exp_t e = base_exp(flush);
        e.mreq = 1'b1; e.maddr = maddr;
        return e;
    endfunction

    function automatic exp_t me_ref(logic [63:0] raddr, logic [127:0] rline, logic flush);
        exp_t e = base_exp(flush);
        e.rwe = 1'b1; e.raddr = raddr; e.rline = rline;
        return e;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".ic_req"},    ic_req_o,       e.icreq);
        check({tag, ".iq_wr"},     iq_wr_o,        e.wr);
        check({tag, ".iq_flush"},  iq_flush_o,     e.flush);
        check({tag, ".mem_req"},   mem_req_o,      e.mreq);
        check({tag, ".refill_we"}, ic_refill_we_o, e.rwe);
        check({tag, ".busy"},      busy_o,         e.busy);
        if (e.icreq) check({tag, ".ic_pc"}, ic_pc_o, e.pc);
        if (e.mreq)  check({tag, ".mem_addr"}, mem_addr_o, e.maddr);
        if (e.rwe) begin
            check({tag, ".refill_addr"}, ic_refill_addr_o, e.raddr);
            check({tag, ".refill_line"}, ic_refill_line_o, e.rline);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step(input string tag, input in_t i, input exp_t e, input bit do_chk);
        rst_i = i.rst; redirect_i = i.redir; redirect_pc_i = i.rpc;
        iq_full_i = i.full; ic_hit_i = i.hit; mem_ack_i = i.ack; mem_line_i = i.line;
        #3;
        if (do_chk) check_out(tag, e);
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: outstanding-request / drop / pending-refill flags instead of an FSM.
    logic [63:0]  m_pc, m_maddr;
    logic         m_out, m_drop, m_refill;
    logic [127:0] m_buf;

    function automatic exp_t model_exp(in_t i);
        exp_t e = base_exp(i.redir);
        e.icreq = !m_out && !m_refill;
        e.mreq  = m_out;
        e.rwe   = m_refill;
        e.busy  = !e.icreq;
        e.wr    = e.icreq && i.hit && !i.full && !i.redir;
        e.pc    = m_pc;
        e.maddr = m_maddr;
        e.raddr = m_pc & ~64'hF;
        e.rline = m_buf;
        return e;
    endfunction

    task automatic model_update(input in_t i);
        logic [63:0] tgt;
        tgt = i.rpc & ~64'h3;
        if (i.rst) begin
            m_pc = 64'h0; m_out = 1'b0; m_drop = 1'b0; m_refill = 1'b0; m_buf = '0;
        end else if (!m_out && !m_refill) begin
            if (i.redir) m_pc = tgt;
            else if (i.hit && !i.full) m_pc = (m_pc & ~64'hF) + 64'd16;
            else if (!i.hit) begin
                m_out = 1'b1; m_drop = 1'b0; m_maddr = m_pc & ~64'hF;
            end
        end else if (m_refill) begin
            m_refill = 1'b0;
            if (i.redir) m_pc = tgt;
        end else begin
            if (i.redir) begin
                m_pc = tgt; m_drop = 1'b1;
            end
            if (i.ack) begin
                m_out = 1'b0;
                if (!m_drop) begin
                    m_refill = 1'b1; m_buf = i.line;
                end
            end
        end
    endtask

    vec_t tbl[27];
    in_t  idle, hitv, rst_in;

    initial begin
        idle = mi(0, 0, 0, 0, 0, '0);
        hitv = mi(0, 0, 0, 1, 0, '0);
        rst_in = idle; rst_in.rst = 1'b1;

        tbl[0]  = '{hitv, me_lk(64'h0, 1, 0)};
        tbl[1]  = '{hitv, me_lk(64'h10, 1, 0)};
        tbl[2]  = '{hitv, me_lk(64'h20, 1, 0)};
        tbl[3]  = '{hitv, me_lk(64'h30, 1, 0)};
        tbl[4]  = '{mi(1, 64'h22, 0, 1, 0, '0), me_lk(64'h40, 0, 1)};
        tbl[5]  = '{mi(0, 0, 1, 1, 0, '0), me_lk(64'h20, 0, 0)};
        tbl[6]  = '{mi(0, 0, 1, 1, 0, '0), me_lk(64'h20, 0, 0)};
        tbl[7]  = '{mi(0, 0, 1, 1, 0, '0), me_lk(64'h20, 0, 0)};
        tbl[8]  = '{hitv, me_lk(64'h20, 1, 0)};
        tbl[9]  = '{mi(1, 64'h44, 0, 1, 0, '0), me_lk(64'h30, 0, 1)};
        tbl[10] = '{idle, me_lk(64'h44, 0, 0)};
        tbl[11] = '{idle, me_miss(64'h40, 0)};
        tbl[12] = '{hitv, me_miss(64'h40, 0)};
        tbl[13] = '{idle, me_miss(64'h40, 0)};
        tbl[14] = '{hitv, me_miss(64'h40, 0)};
        tbl[15] = '{mi(0, 0, 0, 0, 1, LINE_A5), me_miss(64'h40, 0)};
        tbl[16] = '{idle, me_ref(64'h40, LINE_A5, 0)};
        tbl[17] = '{hitv, me_lk(64'h44, 1, 0)};
        tbl[18] = '{idle, me_lk(64'h50, 0, 0)};
        tbl[19] = '{idle, me_miss(64'h50, 0)};
        tbl[20] = '{mi(1, 64'h1002, 0, 0, 0, '0), me_miss(64'h50, 1)};
        tbl[21] = '{idle, me_miss(64'h50, 0)};
        tbl[22] = '{mi(0, 0, 0, 0, 1, JUNK), me_miss(64'h50, 0)};
        tbl[23] = '{hitv, me_lk(64'h1000, 1, 0)};
        tbl[24] = '{idle, me_lk(64'h1010, 0, 0)};
        tbl[25] = '{mi(1, 64'h2000, 0, 0, 1, JUNK), me_miss(64'h1010, 1)};
        tbl[26] = '{hitv, me_lk(64'h2000, 1, 0)};

        @(posedge clk_i);
        #1;
        step("rst0", rst_in, me_lk(64'h0, 0, 0), 0);
        step("rst1", rst_in, me_lk(64'h0, 0, 0), 1);

        for (int k = 0; k < 27; k++) begin
            step($sformatf("tbl%0d", k), tbl[k].i, tbl[k].e, 1);
        end

        // Wrap at the top of the address space, then hold under back-pressure at 0.
        step("wrap0", mi(1, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, '0), me_lk(64'h2010, 0, 1), 1);
        step("wrap1", hitv, me_lk(64'hFFFF_FFFF_FFFF_FFF0, 1, 0), 1);
        step("wrap2", mi(0, 0, 1, 1, 0, '0), me_lk(64'h0, 0, 0), 1);

        // Reset beats a simultaneous redirect; redirect during REFILL keeps the write.
        begin
            in_t rr;
            rr = rst_in; rr.redir = 1'b1; rr.rpc = 64'h500;
            step("rst_redir", rr, me_lk(64'h0, 0, 0), 0);
        end
        step("post_rst", idle, me_lk(64'h0, 0, 0), 1);
        step("miss0", mi(0, 0, 0, 0, 1, LINE_2), me_miss(64'h0, 0), 1);
        step("ref_redir", mi(1, 64'h3004, 0, 1, 0, '0), me_ref(64'h0, LINE_2, 1), 1);
        step("after_ref", hitv, me_lk(64'h3004, 1, 0), 1);

        // Randomized traffic against the reference model, starting from a reset.
        step("rnd_rst", rst_in, me_lk(64'h0, 0, 0), 0);
        model_update(rst_in);
        for (int c = 0; c < 1500; c++) begin
            in_t  ri;
            exp_t re;
            ri.rst   = ($urandom_range(0, 99) == 0);
            ri.redir = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0, 1: ri.rpc = 64'($urandom_range(0, 'h3ff));
                2:    ri.rpc = {32'hFFFF_FFFF, 32'($urandom)};
                default: ri.rpc = {32'($urandom), 32'($urandom)};
            endcase
            ri.full = ($urandom_range(0, 3) == 0);
            ri.hit  = ($urandom_range(0, 9) < 7);
            ri.ack  = m_out && ($urandom_range(0, 3) == 0);
            ri.line = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
            re = model_exp(ri);
            step($sformatf("rnd%0d", c), ri, re, !ri.rst);
            model_update(ri);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
